// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port RAM: data has priority, but fetch is
// granted after MAX_STREAK consecutive data grants it has waited through.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req_i,
  input  logic [AW-1:0] f_addr_i,
  output logic          f_ack_o,
  output logic [DW-1:0] f_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  input  logic [DW-1:0] data_i,
  output logic          busy_o
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [2:0]    lat_cnt;
  logic          sel_data;
  logic          cur_we;
  logic          grant_data;

  // Data wins any contest unless fetch has already sat through MAX_STREAK data grants.
  assign grant_data = d_req_i && !(f_req_i && (streak == SW'(MAX_STREAK)));
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      lat_cnt   <= '0;
      sel_data  <= 1'b0;
      cur_we    <= 1'b0;
      we_o      <= 1'b0;
      addr_o    <= '0;
      data_o    <= '0;
      f_ack_o   <= 1'b0;
      d_ack_o   <= 1'b0;
      f_rdata_o <= '0;
      d_rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req_i || f_req_i) begin
            sel_data <= grant_data;
            cur_we   <= grant_data && d_we_i;
            we_o     <= grant_data && d_we_i;
            addr_o   <= grant_data ? d_addr_i : f_addr_i;
            data_o   <= grant_data ? d_wdata_i : '0;
            lat_cnt  <= 3'(RD_LATENCY);
            streak   <= (grant_data && f_req_i) ? SW'(streak + 1'b1) : '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          we_o <= 1'b0;
          // Stores finish after one cycle; loads wait out the RAM read latency.
          if (cur_we || (lat_cnt == 3'd0)) begin
            if (!cur_we) begin
              if (sel_data) d_rdata_o <= data_i;
              else          f_rdata_o <= data_i;
            end
            addr_o  <= '0;
            data_o  <= '0;
            f_ack_o <= !sel_data;
            d_ack_o <= sel_data;
            state   <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          f_ack_o <= 1'b0;
          d_ack_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances at read latencies 1, 3, 0 and 7, each
// with a RAM model whose read data is only valid exactly RD_LATENCY cycles in.
module tb_mem_arbiter;

  localparam logic [15:0] LATS = 16'h7031;  // nibble k = RD_LATENCY of instance k

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, ram_init;
  logic        f_req [4], f_ack [4], d_req [4], d_we [4], d_ack [4], we [4], busy [4];
  logic [31:0] f_addr [4], f_rdata [4], d_addr [4], d_wdata [4], d_rdata [4];
  logic [31:0] addr [4], wdat [4], rdat [4];
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int          n_vec = 0, n_err = 0, done_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input int i);
    return (32'(i + 1) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  function automatic int lat_of(input int k);
    return int'(LATS[k*4 +: 4]);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    if (ram_init) for (int i = 0; i < 256; i++) ram[i] <= hash(i);
    else if (we[0]) ram[addr[0][9:2]] <= wdat[0];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int RL = int'(LATS[gi*4 +: 4]);
    logic [31:0] last_addr;
    logic [3:0]  age, age_now;
    // age_now counts cycles the current address has been stable; data is valid only at RL.
    assign age_now = (addr[gi] == last_addr) ? age + 4'd1 : 4'd0;
    assign rdat[gi] = (age_now == 4'(RL)) ? ram[addr[gi][9:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
      last_addr <= addr[gi];
      age       <= age_now;
    end
    mem_arbiter #(.AW(32), .DW(32), .RD_LATENCY(RL), .MAX_STREAK(4)) u_dut (
      .clk(clk), .reset(reset),
      .f_req_i(f_req[gi]), .f_addr_i(f_addr[gi]), .f_ack_o(f_ack[gi]), .f_rdata_o(f_rdata[gi]),
      .d_req_i(d_req[gi]), .d_we_i(d_we[gi]), .d_addr_i(d_addr[gi]), .d_wdata_i(d_wdata[gi]),
      .d_ack_o(d_ack[gi]), .d_rdata_o(d_rdata[gi]),
      .we_o(we[gi]), .addr_o(addr[gi]), .data_o(wdat[gi]), .data_i(rdat[gi]), .busy_o(busy[gi])
    );
  end

  function automatic void chk_idle(input int k);
    chk("idle_busy", 32'(busy[k]), 32'h0);
    chk("idle_f_ack", 32'(f_ack[k]), 32'h0);
    chk("idle_d_ack", 32'(d_ack[k]), 32'h0);
    chk("idle_we", 32'(we[k]), 32'h0);
    chk("idle_addr", addr[k], 32'h0);
    chk("idle_data", wdat[k], 32'h0);
    chk("idle_f_rdata", f_rdata[k], 32'h0);
    chk("idle_d_rdata", d_rdata[k], 32'h0);
  endfunction

  // One isolated request on instance k, checked cycle by cycle from T0 to the ack.
  task automatic single_txn(input int k, input vec_t v);
    int lat;
    logic [31:0] other;
    lat   = v.we ? 2 : lat_of(k) + 2;
    @(posedge clk); #1;
    other = v.is_d ? f_rdata[k] : d_rdata[k];
    if (v.is_d) begin
      d_req[k] = 1'b1; d_we[k] = v.we; d_addr[k] = v.addr; d_wdata[k] = v.wdata;
    end else begin
      f_req[k] = 1'b1; f_addr[k] = v.addr;
    end
    for (int n = 0; n <= lat; n++) begin
      @(negedge clk);
      chk("busy", 32'(busy[k]), 32'(n > 0));
      chk("f_ack", 32'(f_ack[k]), 32'(n == lat && !v.is_d));
      chk("d_ack", 32'(d_ack[k]), 32'(n == lat && v.is_d));
      chk("we", 32'(we[k]), 32'(n == 1 && v.we));
      if (n >= 1 && n < lat) chk("addr", addr[k], v.addr);
      if (n == 1) chk("data_out", wdat[k], v.is_d ? v.wdata : 32'h0);
      if (n == lat) begin
        chk("addr_clr", addr[k], 32'h0);
        chk("data_clr", wdat[k], 32'h0);
      end
    end
    if (!v.we) chk("rdata", v.is_d ? d_rdata[k] : f_rdata[k], v.exp_rdata);
    chk("other_rdata", v.is_d ? f_rdata[k] : d_rdata[k], other);
    if (v.we) ref_mem[v.addr[9:2]] = v.wdata;
    $display("txn k=%0d %s we=%0d addr=%h wdata=%h rdata=%h", k, v.is_d ? "data" : "fetch",
             v.we, v.addr, v.wdata, v.is_d ? d_rdata[k] : f_rdata[k]);
    @(posedge clk); #1;
    f_req[k] = 1'b0; d_req[k] = 1'b0;
    @(negedge clk);
    chk("busy_after", 32'(busy[k]), 32'h0);
  endtask

  // Random requester on instance 0; data uses 0x200..0x3FC, fetch reads 0x004..0x1FC.
  task automatic run_port(input bit is_d, input int n);
    for (int i = 0; i < n; i++) begin
      bit w, acked;
      logic [31:0] a, wd, got;
      w  = is_d && ($urandom_range(0, 1) == 1);
      a  = is_d ? 32'h200 + 32'($urandom_range(0, 127)) * 4 : 32'h4 + 32'($urandom_range(0, 126)) * 4;
      wd = $urandom;
      if (is_d) begin
        d_req[0] = 1'b1; d_we[0] = w; d_addr[0] = a; d_wdata[0] = wd;
      end else begin
        f_req[0] = 1'b1; f_addr[0] = a;
      end
      acked = 1'b0;
      for (int c = 0; c < 60 && !acked; c++) begin
        @(negedge clk);
        acked = is_d ? d_ack[0] : f_ack[0];
      end
      chk(is_d ? "d_ack_timeout" : "f_ack_timeout", 32'(acked), 32'h1);
      got = is_d ? d_rdata[0] : f_rdata[0];
      if (!w) chk(is_d ? "d_rand_rdata" : "f_rand_rdata", got, ref_mem[a[9:2]]);
      else    ref_mem[a[9:2]] = wd;
      $display("rand %s we=%0d addr=%h wdata=%h rdata=%h", is_d ? "data" : "fetch", w, a, wd, got);
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) begin
        if (is_d) d_req[0] = 1'b0; else f_req[0] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    if (is_d) d_req[0] = 1'b0; else f_req[0] = 1'b0;
    done_cnt++;
  endtask

  // Reference arbitration: track how many data grants fetch has waited through.
  task automatic monitor();
    bit pend = 1'b0, exp_d = 1'b0, fpend = 1'b0;
    int waited = 0;
    for (int c = 0; c < 20000 && done_cnt < 2; c++) begin
      @(negedge clk);
      chk("dual_ack", 32'(f_ack[0] & d_ack[0]), 32'h0);
      if (pend && (f_ack[0] || d_ack[0])) begin
        chk("arb_winner", 32'(d_ack[0]), 32'(exp_d));
        waited = (exp_d && fpend) ? waited + 1 : 0;
        pend = 1'b0;
      end
      if (!busy[0] && (f_req[0] || d_req[0])) begin
        exp_d = d_req[0] && !(f_req[0] && waited >= 4);
        fpend = f_req[0];
        pend  = 1'b1;
      end
    end
    chk("monitor_done", 32'(done_cnt), 32'd2);
  endtask

  initial begin
    vec_t vecs [9];
    string order;
    logic [31:0] frd;
    reset = 1'b1; ram_init = 1'b1;
    for (int k = 0; k < 4; k++) begin
      f_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      f_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = hash(i);
    vecs[0] = '{1'b1, 1'b1, 32'h040, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'h1234_5678, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h040, 32'h0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b1, 32'h040, 32'hCAFE_F00D, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h040, 32'h0, 32'hCAFE_F00D};
    vecs[7] = '{1'b0, 1'b0, 32'h044, 32'h0, hash(17)};
    vecs[8] = '{1'b1, 1'b0, 32'h3FC, 32'h0, hash(255)};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; ram_init = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk_idle(k);

    for (int i = 0; i < 9; i++) single_txn(0, vecs[i]);

    // Reset in the middle of a latency-3 read aborts it cleanly.
    @(posedge clk); #1;
    f_req[1] = 1'b1; f_addr[1] = 32'h20;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; f_req[1] = 1'b0;
    @(negedge clk);
    chk("busy_before_rst", 32'(busy[1]), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle(1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_ack_after_rst", 32'(f_ack[1] | d_ack[1]), 32'h0);
    end
    single_txn(1, '{1'b0, 1'b0, 32'h024, 32'h0, ref_mem[9]});

    // Both requesters held: grant order must be DDDDFDDDDF.
    @(posedge clk); #1;
    frd = f_rdata[0];
    order = "";
    f_req[0] = 1'b1; f_addr[0] = 32'h80;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h104;
    for (int c = 0; c < 200 && order.len() < 10; c++) begin
      @(negedge clk);
      if (d_ack[0]) begin
        order = {order, "D"};
        chk("f_rdata_held", f_rdata[0], frd);
        chk("streak_d_rdata", d_rdata[0], ref_mem[65]);
      end
      if (f_ack[0]) begin
        order = {order, "F"};
        frd = f_rdata[0];
        chk("streak_f_rdata", f_rdata[0], ref_mem[32]);
      end
    end
    @(posedge clk); #1;
    f_req[0] = 1'b0; d_req[0] = 1'b0;
    n_vec++;
    if (order != "DDDDFDDDDF") begin
      n_err++;
      $display("FAIL grant_order: got %s expected DDDDFDDDDF", order);
    end
    $display("streak grant order %s", order);

    // Back-to-back fetches at latency 0 and 7.
    for (int k = 2; k < 4; k++) begin
      int t, t1, t2, nack;
      logic [31:0] r1, r2;
      @(posedge clk); #1;
      f_req[k] = 1'b1; f_addr[k] = 32'h10;
      t = 0; t1 = 0; t2 = 0; nack = 0; r1 = '0; r2 = '0;
      for (int c = 0; c < 60 && nack < 2; c++) begin
        @(negedge clk);
        t++;
        if (f_ack[k]) begin
          nack++;
          if (nack == 1) begin
            t1 = t; r1 = f_rdata[k];
            @(posedge clk); #1;
            f_addr[k] = 32'h14;
          end else begin
            t2 = t; r2 = f_rdata[k];
          end
        end
      end
      @(posedge clk); #1;
      f_req[k] = 1'b0;
      chk("ack_spacing", 32'(t2 - t1), 32'(lat_of(k) + 3));
      chk("b2b_rdata1", r1, ref_mem[4]);
      chk("b2b_rdata2", r2, ref_mem[5]);
      $display("b2b k=%0d spacing=%0d rdata=%h,%h", k, t2 - t1, r1, r2);
    end

    // Concurrent random traffic on instance 0 against the arbitration reference.
    @(posedge clk); #1;
    fork
      run_port(1'b1, 30);
      run_port(1'b0, 30);
      monitor();
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
